cam_lut_arbiter: RTL and testbench

CAM_LUT_ARBITER -- requirements
Module: cam_lut_arbiter

---
 rtl/cam_lut_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_cam_lut_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lut_arbiter.sv
// Two-requester round-robin front end for a single-lookup CAM/LUT engine.
// Latency: req_ack is combinational in IDLE; rsp_done arrives 2 cycles + LUT latency after req_ack.
// Backpressure: requesters hold req_valid until req_ack; only one lookup is outstanding at a time.
//
// Ports:
//   clk, reset            - single clock, synchronous active-low reset
//   req_valid/dst/src/op  - two requesters, requester n on the n-th slice of each bus
//   req_ack, rsp_done     - per-requester grant and completion pulses
//   rsp_hit, rsp_miss     - registered lookup result, qualified by rsp_done, held between responses
//   lut_*                 - key/opcode/start towards the LUT, done/hit/miss back from it
//   busy                  - high in every state except IDLE
//   timeout_err           - watchdog abort pulse (constant 0 unless CAM_ARB_WATCHDOG_EN is defined)
//
// Build option: define CAM_ARB_WATCHDOG_EN to add the WAIT-state watchdog (TIMEOUT_CYCLES).

module cam_lut_arbiter #(
    parameter int INIT_CYCLES    = 40,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int OPCODE_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [95:0]           req_dst_ip,
    input  logic [95:0]           req_src_ip,
    input  logic [2*OPCODE_W-1:0] req_opcode,
    output logic [1:0]            req_ack,
    output logic [1:0]            rsp_done,
    output logic                  rsp_hit,
    output logic                  rsp_miss,
    output logic [47:0]           lut_dst_ip,
    output logic [47:0]           lut_src_ip,
    output logic [OPCODE_W-1:0]   lut_opcode,
    output logic                  lut_lookup_req,
    input  logic                  lut_lookup_done,
    input  logic                  lut_hit,
    input  logic                  lut_miss,
    output logic                  busy,
    output logic                  timeout_err
);

    // ------------------------------------------------------------------
    // State encoding (one-hot)
    // ------------------------------------------------------------------
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_IDLE  = 5'b00010,
        S_ISSUE = 5'b00100,
        S_WAIT  = 5'b01000,
        S_RESP  = 5'b10000
    } state_t;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    state_t                state_q;
    logic [INIT_W-1:0]     init_cnt_q;
    logic                  last_q;       // index of the requester granted most recently
    logic                  owner_q;      // index of the requester owning the current lookup
    logic [47:0]           dst_q;
    logic [47:0]           src_q;
    logic [OPCODE_W-1:0]   op_q;
    logic                  lookup_req_q;
    logic [1:0]            rsp_done_q;
    logic                  hit_q;
    logic                  miss_q;
    logic                  busy_q;

`ifdef CAM_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]       wd_cnt_q;
    logic                  timeout_q;
`endif

    // ------------------------------------------------------------------
    // Arbitration (combinational, only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic                  gnt_vld_d;
    logic                  gnt_idx_d;
    logic                  lut_hit_d;
    logic [47:0]           sel_dst_d;
    logic [47:0]           sel_src_d;
    logic [OPCODE_W-1:0]   sel_op_d;

    always_comb begin
        gnt_vld_d = (state_q == S_IDLE) && (req_valid != 2'b00);
        // On a tie the requester that did not win last time goes next;
        // otherwise the lone requester wins.
        if (req_valid == 2'b11) begin
            gnt_idx_d = ~last_q;
        end else begin
            gnt_idx_d = req_valid[1];
        end
        sel_dst_d = gnt_idx_d ? req_dst_ip[95:48] : req_dst_ip[47:0];
        sel_src_d = gnt_idx_d ? req_src_ip[95:48] : req_src_ip[47:0];
        sel_op_d  = gnt_idx_d ? req_opcode[OPCODE_W +: OPCODE_W]
                              : req_opcode[0 +: OPCODE_W];
        // A contradictory LUT answer (hit and miss together) is treated as a miss.
        lut_hit_d = lut_hit & ~lut_miss;
    end

    // Grant is gated by reset so nothing is acknowledged while reset is held.
    assign req_ack = (gnt_vld_d && reset) ? (gnt_idx_d ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            dst_q        <= '0;
            src_q        <= '0;
            op_q         <= '0;
            lookup_req_q <= 1'b0;
            rsp_done_q   <= 2'b00;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            busy_q       <= 1'b1;
`ifdef CAM_ARB_WATCHDOG_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            lookup_req_q <= 1'b0;
            rsp_done_q   <= 2'b00;
`ifdef CAM_ARB_WATCHDOG_EN
            timeout_q    <= 1'b0;
`endif
            case (state_q)
                S_INIT: begin
                    // Hold off while the LUT performs its own reset fill.
                    if (init_cnt_q == INIT_LAST) begin
                        init_cnt_q <= '0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q      <= gnt_idx_d;
                        last_q       <= gnt_idx_d;
                        dst_q        <= sel_dst_d;
                        src_q        <= sel_src_d;
                        op_q         <= sel_op_d;
                        lookup_req_q <= 1'b1;  // high for the single ISSUE cycle
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state_q  <= S_WAIT;
`ifdef CAM_ARB_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                end

                S_WAIT: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (lut_lookup_done) begin
                        hit_q      <= lut_hit_d;
                        miss_q     <= ~lut_hit_d;
                        rsp_done_q <= owner_q ? 2'b10 : 2'b01;
                        state_q    <= S_RESP;
`ifdef CAM_ARB_WATCHDOG_EN
                    end else if (wd_cnt_q == WD_LAST) begin
                        // Abort: report a miss to the owner and flag the timeout.
                        hit_q      <= 1'b0;
                        miss_q     <= 1'b1;
                        rsp_done_q <= owner_q ? 2'b10 : 2'b01;
                        timeout_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wd_cnt_q   <= wd_cnt_q + 1'b1;
`endif
                    end
                end

                S_RESP: begin
                    // rsp_done is visible this cycle; granting resumes next cycle.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= S_INIT;
                    init_cnt_q <= '0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign lut_dst_ip     = dst_q;
    assign lut_src_ip     = src_q;
    assign lut_opcode     = op_q;
    assign lut_lookup_req = lookup_req_q;
    assign rsp_done       = rsp_done_q;
    assign rsp_hit        = hit_q;
    assign rsp_miss       = miss_q;
    assign busy           = busy_q;

`ifdef CAM_ARB_WATCHDOG_EN
    assign timeout_err    = timeout_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cam_lut_arbiter.sv
`timescale 1ns/1ps
module tb_cam_lut_arbiter;

    localparam int OPW = 16;
    localparam logic [47:0] DST0 = 48'h0A00000000A0;
    localparam logic [47:0] DST1 = 48'h0B00000000B1;
    localparam logic [47:0] KEY1 = 48'h0A0000000001;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [95:0]       req_dst_ip;
    logic [95:0]       req_src_ip;
    logic [2*OPW-1:0]  req_opcode;
    logic [1:0]        req_ack;
    logic [1:0]        rsp_done;
    logic              rsp_hit;
    logic              rsp_miss;
    logic [47:0]       lut_dst_ip;
    logic [47:0]       lut_src_ip;
    logic [OPW-1:0]    lut_opcode;
    logic              lut_lookup_req;
    logic              lut_lookup_done;
    logic              lut_hit;
    logic              lut_miss;
    logic              busy;
    logic              timeout_err;

    logic model_en, model_done, manual_done, d1, d2;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign lut_lookup_done = model_done | manual_done;

    cam_lut_arbiter #(.INIT_CYCLES(40), .TIMEOUT_CYCLES(15), .OPCODE_W(OPW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dst_ip(req_dst_ip), .req_src_ip(req_src_ip),
        .req_opcode(req_opcode), .req_ack(req_ack), .rsp_done(rsp_done),
        .rsp_hit(rsp_hit), .rsp_miss(rsp_miss), .lut_dst_ip(lut_dst_ip),
        .lut_src_ip(lut_src_ip), .lut_opcode(lut_opcode), .lut_lookup_req(lut_lookup_req),
        .lut_lookup_done(lut_lookup_done), .lut_hit(lut_hit), .lut_miss(lut_miss),
        .busy(busy), .timeout_err(timeout_err)
    );

    // LUT model: answers two cycles after seeing lut_lookup_req.
    initial begin
        model_done = 1'b0; d1 = 1'b0; d2 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (model_en) begin
                model_done = d2; d2 = d1; d1 = lut_lookup_req;
            end else begin
                model_done = 1'b0; d1 = 1'b0; d2 = 1'b0;
            end
        end
    end

    // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = 2'b00; manual_done = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(40);
    endtask

    task automatic test_reset();
        tick(1);
        @(negedge clk);
        n_checks++;
        if ({req_ack, rsp_done, rsp_hit, rsp_miss, lut_lookup_req, timeout_err, busy} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b done=%b hit=%b miss=%b req=%b to=%b busy=%b, want all 0 and busy=1",
                     req_ack, rsp_done, rsp_hit, rsp_miss, lut_lookup_req, timeout_err, busy);
        end
        n_checks++;
        if ({lut_dst_ip, lut_src_ip, lut_opcode} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got dst=%h src=%h op=%h want 0", lut_dst_ip, lut_src_ip, lut_opcode);
        end
        tick(1);
        reset = 1'b1; req_valid = 2'b01;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (c < 40 && (req_ack !== 2'b00 || busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL init_holdoff c=%0d: got ack=%b busy=%b want ack=00 busy=1", c, req_ack, busy);
            end else if (c == 40 && (req_ack !== 2'b01 || busy !== 1'b0)) begin
                n_fail++;
                $display("FAIL init_first_ack: got ack=%b busy=%b want ack=01 busy=0", req_ack, busy);
            end
            tick(1);
        end
        req_valid = 2'b00;
        tick(5);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp;
        logic [47:0] exp_dst;
        do_reset();
        req_dst_ip = {DST1, DST0};
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp     = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_dst = (k % 2 == 1) ? DST1 : DST0;
            @(negedge clk);
            n_checks++;
            if (req_ack !== exp) begin
                n_fail++; $display("FAIL rr_ack k=%0d: got %b want %b", k, req_ack, exp);
            end
            tick(1);
            @(negedge clk);
            n_checks++;
            if (lut_lookup_req !== 1'b1 || lut_dst_ip !== exp_dst) begin
                n_fail++; $display("FAIL rr_issue k=%0d: got req=%b dst=%h want req=1 dst=%h", k, lut_lookup_req, lut_dst_ip, exp_dst);
            end
            tick(1);
            @(negedge clk);
            n_checks++;
            if (req_ack !== 2'b00 || lut_lookup_req !== 1'b0) begin
                n_fail++; $display("FAIL rr_wait k=%0d: got ack=%b req=%b want 00/0", k, req_ack, lut_lookup_req);
            end
            tick(2);
            @(negedge clk);
            n_checks++;
            if (rsp_done !== exp || rsp_hit !== 1'b1 || req_ack !== 2'b00) begin
                n_fail++; $display("FAIL rr_done k=%0d: got done=%b hit=%b ack=%b want done=%b hit=1 ack=00", k, rsp_done, rsp_hit, req_ack, exp);
            end
            tick(1);
        end
        req_valid = 2'b00;
        tick(1);
    endtask

    task automatic test_hit_path();
        req_dst_ip = {KEY1, 48'h111111111111};
        req_src_ip = {48'h0A0000000002, 48'h222222222222};
        req_opcode = {16'hBEEF, 16'h1234};
        req_valid  = 2'b10;
        @(negedge clk);
        n_checks++;
        if (req_ack !== 2'b10) begin
            n_fail++; $display("FAIL hit_ack: got %b want 10", req_ack);
        end
        tick(1);
        req_valid = 2'b00; req_dst_ip = '1; req_src_ip = '1; req_opcode = '1;
        @(negedge clk);
        n_checks++;
        if (lut_lookup_req !== 1'b1 || lut_dst_ip !== KEY1 || lut_src_ip !== 48'h0A0000000002 || lut_opcode !== 16'hBEEF) begin
            n_fail++; $display("FAIL hit_issue: got req=%b dst=%h src=%h op=%h", lut_lookup_req, lut_dst_ip, lut_src_ip, lut_opcode);
        end
        for (int w = 0; w < 2; w++) begin
            tick(1);
            @(negedge clk);
            n_checks++;
            if (lut_lookup_req !== 1'b0 || lut_dst_ip !== KEY1 || rsp_done !== 2'b00) begin
                n_fail++; $display("FAIL hit_wait w=%0d: got req=%b dst=%h done=%b want 0/%h/00", w, lut_lookup_req, lut_dst_ip, rsp_done, KEY1);
            end
        end
        tick(1);
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b10 || rsp_hit !== 1'b1 || rsp_miss !== 1'b0) begin
            n_fail++; $display("FAIL hit_done: got done=%b hit=%b miss=%b want 10/1/0", rsp_done, rsp_hit, rsp_miss);
        end
        tick(1);
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b00 || rsp_hit !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hit_hold: got done=%b hit=%b busy=%b want 00/1/0", rsp_done, rsp_hit, busy);
        end
        tick(1);
    endtask

    task automatic test_result_table();
        logic [3:0] vec [4];  // {lut_hit, lut_miss, exp_hit, exp_miss}
        vec[0] = 4'b1101; vec[1] = 4'b0101; vec[2] = 4'b0001; vec[3] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            lut_hit = vec[i][3]; lut_miss = vec[i][2];
            req_valid = 2'b01;
            tick(1);
            req_valid = 2'b00;
            tick(3);
            @(negedge clk);
            n_checks++;
            if (rsp_done !== 2'b01 || {rsp_hit, rsp_miss} !== vec[i][1:0]) begin
                n_fail++; $display("FAIL result_vec i=%0d: got done=%b hit/miss=%b%b want 01/%b", i, rsp_done, rsp_hit, rsp_miss, vec[i][1:0]);
            end
            tick(1);
        end
    endtask

    task automatic test_spurious_done();
        lut_hit = 1'b0; lut_miss = 1'b1; manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b00 || rsp_hit !== 1'b1 || rsp_miss !== 1'b0 || busy !== 1'b0 || lut_lookup_req !== 1'b0) begin
            n_fail++; $display("FAIL spurious_done: got done=%b hit=%b miss=%b busy=%b req=%b want 00/1/0/0/0",
                               rsp_done, rsp_hit, rsp_miss, busy, lut_lookup_req);
        end
        tick(1);
        lut_hit = 1'b1; lut_miss = 1'b0;
    endtask

    task automatic test_watchdog();
        model_en = 1'b0;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
`ifdef CAM_ARB_WATCHDOG_EN
        tick(1);
        for (int w = 0; w < 15; w++) begin
            @(negedge clk);
            n_checks++;
            if (timeout_err !== 1'b0 || rsp_done !== 2'b00) begin
                n_fail++; $display("FAIL wd_early w=%0d: got to=%b done=%b want 0/00", w, timeout_err, rsp_done);
            end
            tick(1);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b1 || rsp_done !== 2'b01 || rsp_hit !== 1'b0 || rsp_miss !== 1'b1) begin
            n_fail++; $display("FAIL wd_abort: got to=%b done=%b hit=%b miss=%b want 1/01/0/1", timeout_err, rsp_done, rsp_hit, rsp_miss);
        end
        tick(1);
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wd_idle: got to=%b busy=%b want 0/0", timeout_err, busy);
        end
        tick(1);
        model_en = 1'b1; req_valid = 2'b10;
        @(negedge clk);
        n_checks++;
        if (req_ack !== 2'b10) begin
            n_fail++; $display("FAIL wd_regrant: got ack=%b want 10", req_ack);
        end
        tick(1);
        req_valid = 2'b00;
        tick(3);
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b10 || rsp_hit !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_normal: got done=%b hit=%b to=%b want 10/1/0", rsp_done, rsp_hit, timeout_err);
        end
        tick(1);
        // Done on the final watchdog cycle completes normally.
        model_en = 1'b0;
        req_valid = 2'b01;
        tick(1);
        req_valid = 2'b00;
        tick(15);
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b01 || timeout_err !== 1'b0 || rsp_hit !== 1'b1) begin
            n_fail++; $display("FAIL wd_priority: got done=%b to=%b hit=%b want 01/0/1", rsp_done, timeout_err, rsp_hit);
        end
        tick(1);
`else
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || timeout_err !== 1'b0 || rsp_done !== 2'b00) begin
                n_fail++; $display("FAIL nowd_wait w=%0d: got busy=%b to=%b done=%b want 1/0/00", w, busy, timeout_err, rsp_done);
            end
            tick(1);
        end
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_done !== 2'b01 || rsp_hit !== 1'b1) begin
            n_fail++; $display("FAIL nowd_late_done: got done=%b hit=%b want 01/1", rsp_done, rsp_hit);
        end
        tick(1);
`endif
        model_en = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        model_en = 1'b0; lut_hit = 1'b1; lut_miss = 1'b0;
        req_dst_ip = {DST1, DST0};
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++;
        if (req_ack !== 2'b10) begin
            n_fail++; $display("FAIL rw_ack: got %b want 10", req_ack);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || rsp_done !== 2'b00 || lut_dst_ip !== 48'h0 || req_ack !== 2'b00 || lut_lookup_req !== 1'b0) begin
            n_fail++; $display("FAIL rw_in_reset: got busy=%b done=%b dst=%h ack=%b req=%b", busy, rsp_done, lut_dst_ip, req_ack, lut_lookup_req);
        end
        tick(1);
        reset = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            if (c == 1) manual_done = 1'b1;
            if (c == 2) manual_done = 1'b0;
            if (c == 35) model_en = 1'b1;
            @(negedge clk);
            n_checks++;
            if (c < 40 && (req_ack !== 2'b00 || rsp_done !== 2'b00 || busy !== 1'b1)) begin
                n_fail++; $display("FAIL rw_init c=%0d: got ack=%b done=%b busy=%b want 00/00/1", c, req_ack, rsp_done, busy);
            end else if (c == 40 && (req_ack !== 2'b10 || rsp_done !== 2'b00 || rsp_hit !== 1'b0 || busy !== 1'b0)) begin
                n_fail++; $display("FAIL rw_reack: got ack=%b done=%b hit=%b busy=%b want 10/00/0/0", req_ack, rsp_done, rsp_hit, busy);
            end
            tick(1);
        end
        req_valid = 2'b00;
        tick(5);
    endtask

    initial begin
        reset = 1'b0; req_valid = 2'b00; req_dst_ip = '0; req_src_ip = '0; req_opcode = '0;
        lut_hit = 1'b1; lut_miss = 1'b0; manual_done = 1'b0; model_en = 1'b1;
        test_reset();
        test_back_to_back();
        test_hit_path();
        test_result_table();
        test_spurious_done();
        test_watchdog();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "bench timeout");
    end

endmodule
